mem_port_arbiter: RTL and testbench

//  Shares the single-ported unified memory between the fetch requester (if_*) and the MEM-stage data requester (dm_*).

---
 rtl/tartaruga_pkg.sv | 37 +++
 rtl/arb_perf_cnt.sv | 34 +++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga memory port arbiter: FSM states, owner select and the muxed
// memory request record.
package tartaruga_pkg;

  localparam int unsigned ArbAddrW = 32;
  localparam int unsigned ArbDataW = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_DM,
    DRAIN
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [ArbDataW/8-1:0] be;
    logic [ArbAddrW-1:0]   addr;
    logic [ArbDataW-1:0]   wdata;
  } mem_req_t;

  // Fetches are always full-word reads.
  function automatic mem_req_t fetch_req(logic [ArbAddrW-1:0] addr);
    mem_req_t r;
    r.we    = 1'b0;
    r.be    = '1;
    r.addr  = addr;
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/arb_perf_cnt.sv
// Arbiter performance counters: fetch grants, data grants and IDLE conflict cycles.
// Counters wrap modulo 2^CNT_W.
module arb_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             if_gnt_i,
  input  logic             dm_gnt_i,
  input  logic             conflict_i,
  output logic [CNT_W-1:0] perf_if_gnt_o,
  output logic [CNT_W-1:0] perf_dm_gnt_o,
  output logic [CNT_W-1:0] perf_conflict_o
);

  logic [CNT_W-1:0] if_cnt_q, dm_cnt_q, cf_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      if_cnt_q <= '0;
      dm_cnt_q <= '0;
      cf_cnt_q <= '0;
    end else begin
      if (if_gnt_i)   if_cnt_q <= if_cnt_q + CNT_W'(1);
      if (dm_gnt_i)   dm_cnt_q <= dm_cnt_q + CNT_W'(1);
      if (conflict_i) cf_cnt_q <= cf_cnt_q + CNT_W'(1);
    end
  end

  assign perf_if_gnt_o   = if_cnt_q;
  assign perf_dm_gnt_o   = dm_cnt_q;
  assign perf_conflict_o = cf_cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between fetch (if_*) and data (dm_*), one
// transaction in flight. Optional perf counters under TARTARUGA_ARB_PERF_EN.
module mem_port_arbiter
  import tartaruga_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                flush_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef TARTARUGA_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]    perf_if_gnt_o,
  output logic [CNT_W-1:0]    perf_dm_gnt_o,
  output logic [CNT_W-1:0]    perf_conflict_o
`endif
);

  localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);

  if (STARVE_LIMIT < 1 || CNT_W < 1) begin : g_bad_param
    $error("STARVE_LIMIT and CNT_W must be >= 1");
  end

  arb_state_e     state_q, state_d;
  logic [StW-1:0] starve_q, starve_d;
  arb_owner_e     owner;
  mem_req_t       mreq;
  logic           if_req_eff;
  logic           starve_hit;

  assign if_req_eff = if_req_i & ~flush_i;
  assign starve_hit = (starve_q == StW'(STARVE_LIMIT));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    owner       = OWN_DM;
    mreq        = '0;
    mem_req_o   = 1'b0;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_gnt_o    = 1'b0;
    dm_rvalid_o = 1'b0;
    dm_rdata_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (dm_req_i || if_req_eff) begin
          mem_req_o = 1'b1;
          owner = (if_req_eff && (!dm_req_i || starve_hit)) ? OWN_IF : OWN_DM;
          if (owner == OWN_IF) begin
            mreq     = fetch_req(ArbAddrW'(if_addr_i));
            if_gnt_o = mem_gnt_i;
            if (mem_gnt_i) begin
              state_d  = WAIT_IF;
              starve_d = '0;
            end
          end else begin
            mreq.we    = dm_we_i;
            mreq.be    = (ArbDataW/8)'(dm_be_i);
            mreq.addr  = ArbAddrW'(dm_addr_i);
            mreq.wdata = ArbDataW'(dm_wdata_i);
            dm_gnt_o   = mem_gnt_i;
            if (mem_gnt_i) begin
              state_d = WAIT_DM;
              // A lost conflict counts toward the fetch starvation guard.
              if (if_req_eff && !starve_hit) starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      WAIT_IF: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (!flush_i) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      WAIT_DM: begin
        if (mem_rvalid_i) begin
          state_d     = IDLE;
          dm_rvalid_o = 1'b1;
          dm_rdata_o  = mem_rdata_i;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we_o    = mreq.we;
  assign mem_be_o    = mreq.be[DATA_W/8-1:0];
  assign mem_addr_o  = mreq.addr[ADDR_W-1:0];
  assign mem_wdata_o = mreq.wdata[DATA_W-1:0];

`ifdef TARTARUGA_ARB_PERF_EN
  arb_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .if_gnt_i        (if_gnt_o),
    .dm_gnt_i        (dm_gnt_o),
    .conflict_i      ((state_q == IDLE) && if_req_i && dm_req_i),
    .perf_if_gnt_o   (perf_if_gnt_o),
    .perf_dm_gnt_o   (perf_dm_gnt_o),
    .perf_conflict_o (perf_conflict_o)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter, plus hand sequences for flush drain and
// the fetch starvation guard.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        rstn;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rv;
    logic [31:0] if_rd;
    logic        dm_gnt;
    logic        dm_rv;
    logic [31:0] dm_rd;
    logic        mreq;
    logic        mwe;
    logic [3:0]  mbe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn_i, flush_i, if_req_i, dm_req_i, dm_we_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [3:0]  dm_be_i, mem_be_o;
  logic        if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
`ifdef TARTARUGA_ARB_PERF_EN
  logic [31:0] perf_if_gnt_o, perf_dm_gnt_o, perf_conflict_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .flush_i      (flush_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .dm_req_i     (dm_req_i),
    .dm_we_i      (dm_we_i),
    .dm_be_i      (dm_be_i),
    .dm_addr_i    (dm_addr_i),
    .dm_wdata_i   (dm_wdata_i),
    .dm_gnt_o     (dm_gnt_o),
    .dm_rvalid_o  (dm_rvalid_o),
    .dm_rdata_o   (dm_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
`ifdef TARTARUGA_ARB_PERF_EN
    ,
    .perf_if_gnt_o   (perf_if_gnt_o),
    .perf_dm_gnt_o   (perf_dm_gnt_o),
    .perf_conflict_o (perf_conflict_o)
`endif
  );

  function automatic in_t mk_in(logic rstn, logic flush, logic if_req, logic [31:0] if_addr,
                                logic dm_req, logic dm_we, logic [3:0] dm_be,
                                logic [31:0] dm_addr, logic [31:0] dm_wdata, logic gnt,
                                logic rv, logic [31:0] rdata);
    return '{rstn, flush, if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, gnt, rv,
             rdata};
  endfunction

  function automatic out_t mk_out(logic if_gnt, logic if_rv, logic [31:0] if_rd, logic dm_gnt,
                                  logic dm_rv, logic [31:0] dm_rd, logic mreq, logic mwe,
                                  logic [3:0] mbe, logic [31:0] maddr, logic [31:0] mwdata);
    return '{if_gnt, if_rv, if_rd, dm_gnt, dm_rv, dm_rd, mreq, mwe, mbe, maddr, mwdata};
  endfunction

  task automatic drive(input in_t i);
    rstn_i       = i.rstn;
    flush_i      = i.flush;
    if_req_i     = i.if_req;
    if_addr_i    = i.if_addr;
    dm_req_i     = i.dm_req;
    dm_we_i      = i.dm_we;
    dm_be_i      = i.dm_be;
    dm_addr_i    = i.dm_addr;
    dm_wdata_i   = i.dm_wdata;
    mem_gnt_i    = i.gnt;
    mem_rvalid_i = i.rv;
    mem_rdata_i  = i.rdata;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic step(input string name, input in_t i, input out_t o);
    out_t act;
    drive(i);
    #2;
    act = {if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o, mem_req_o,
           mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
    n_cmp++;
    if (act !== o) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, o);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  task automatic add(input string n, input in_t i, input out_t o);
    vec_t v;
    v.name = n;
    v.i    = i;
    v.o    = o;
    vecs.push_back(v);
  endtask

  out_t z;
  in_t  idle_in;
  int   exp_if[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    z       = '0;
    idle_in = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    add("rst0", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
    add("rst1", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
    // fetch read with one wait cycle before grant
    add("t1_req", mk_in(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0),
        mk_out(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h100, 0));
    add("t1_gnt", mk_in(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0),
        mk_out(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h100, 0));
    add("t1_wait", idle_in, z);
    add("t1_rv", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF),
        mk_out(0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0));
    add("t1_idle", idle_in, z);
    // conflict: data store wins, then the waiting fetch
    add("t2_both", mk_in(1, 0, 1, 32'h100, 1, 1, 4'hF, 32'h200, 32'h12345678, 1, 0, 0),
        mk_out(0, 0, 0, 1, 0, 0, 1, 1, 4'hF, 32'h200, 32'h12345678));
    add("t2_dmrv", mk_in(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 32'h55),
        mk_out(0, 0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 0));
    add("t2_ifgnt", mk_in(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0),
        mk_out(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h100, 0));
    add("t2_ifrv", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5),
        mk_out(0, 1, 32'hA5, 0, 0, 0, 0, 0, 0, 0, 0));
    add("fl_mask", mk_in(1, 1, 1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0), z);
    add("stray", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234), z);
    // flush coinciding with the fetch response drops it
    add("t5_gnt", mk_in(1, 0, 1, 32'h140, 0, 0, 0, 0, 0, 1, 0, 0),
        mk_out(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h140, 0));
    add("t5_flrv", mk_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77), z);
    add("t5_dm", mk_in(1, 0, 0, 0, 1, 0, 4'hF, 32'h300, 0, 1, 0, 0),
        mk_out(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 32'h300, 0));
    add("t5_dmfl", mk_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99),
        mk_out(0, 0, 0, 0, 1, 32'h99, 0, 0, 0, 0, 0));
    // reset while waiting on data, then a late response
    add("t6_gnt", mk_in(1, 0, 0, 0, 1, 1, 4'h3, 32'h400, 32'hCAFE, 1, 0, 0),
        mk_out(0, 0, 0, 1, 0, 0, 1, 1, 4'h3, 32'h400, 32'hCAFE));
    add("t6_rst", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
    add("t6_late", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD), z);
    add("t6_idle", mk_in(1, 0, 0, 0, 1, 0, 4'hF, 32'h404, 0, 0, 0, 0),
        mk_out(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h404, 0));

    foreach (vecs[k]) step(vecs[k].name, vecs[k].i, vecs[k].o);

    // Flush one cycle after fetch grant: drain, response 3 cycles after flush is swallowed.
    step("t4_gnt", mk_in(1, 0, 1, 32'h180, 0, 0, 0, 0, 0, 1, 0, 0),
         mk_out(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h180, 0));
    step("t4_fl", mk_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
    step("t4_dr1", mk_in(1, 0, 0, 0, 1, 0, 4'hF, 32'h500, 0, 1, 0, 0), z);
    step("t4_dr2", mk_in(1, 0, 0, 0, 1, 0, 4'hF, 32'h500, 0, 1, 0, 0), z);
    step("t4_drv", mk_in(1, 0, 0, 0, 1, 0, 4'hF, 32'h500, 0, 1, 1, 32'h66), z);
    step("t4_dm", mk_in(1, 0, 0, 0, 1, 0, 4'hF, 32'h500, 0, 1, 0, 0),
         mk_out(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 32'h500, 0));
    step("t4_dmrv", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h88),
         mk_out(0, 0, 0, 0, 1, 32'h88, 0, 0, 0, 0, 0));

    // Starvation guard: both requests held, memory grants at once and answers next cycle.
    step("t3_rst", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
    begin
      int   ng   = 0;
      logic pend = 1'b0;
      for (int c = 0; c < 40 && ng < 10; c++) begin
        drive(mk_in(1, 0, 1, 32'h100, 1, 1, 4'hF, 32'h200, 32'h1, 1, pend, 32'h0));
        #2;
        if (if_gnt_o || dm_gnt_o) begin
          n_cmp++;
          if (if_gnt_o !== exp_if[ng][0] || dm_gnt_o !== !exp_if[ng][0]) begin
            n_fail++;
            $display("FAIL t3_grant%0d: got if_gnt=%b dm_gnt=%b required if_gnt=%0d",
                     ng, if_gnt_o, dm_gnt_o, exp_if[ng]);
          end
          ng++;
          pend = 1'b1;
        end else begin
          pend = 1'b0;
        end
        @(posedge clk);
        #1;
      end
      n_cmp++;
      if (ng != 10) begin
        n_fail++;
        $display("FAIL t3_count: got %0d grants required 10", ng);
      end
    end
`ifdef TARTARUGA_ARB_PERF_EN
    n_cmp++;
    if (perf_dm_gnt_o !== 32'd8 || perf_if_gnt_o !== 32'd2) begin
      n_fail++;
      $display("FAIL t3_perf: got dm=%0d if=%0d required dm=8 if=2", perf_dm_gnt_o,
               perf_if_gnt_o);
    end
`endif
    step("t3_lastrv", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h42),
         mk_out(0, 1, 32'h42, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
